// File: rtl/buff_uart_pkg.sv
// Shared definitions for the buffered UART register port: driver FSM states
// and the register map / status bit positions also used by the UART's decode.
package buff_uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    STAT_REQ,
    STAT_WAIT,
    RX_REQ,
    RX_WAIT,
    TX_WRITE
  } driver_state_t;

  typedef enum logic {
    SERVED_RX,
    SERVED_TX
  } last_served_t;

  localparam int RX_ADDR      = 0;
  localparam int TX_ADDR      = 1;
  localparam int STATUS_ADDR  = 2;
  localparam int RX_READY_BIT = 0;
  localparam int TX_READY_BIT = 1;

endpackage

// File: rtl/buff_uart_driver.sv
// Bus initiator that polls the UART status register and moves bytes between
// host valid/ready streams and the UART FIFOs. BUFF_UART_DRIVER_STATS_EN adds
// 16-bit rx_count/tx_count transfer counters.
module buff_uart_driver
  import buff_uart_pkg::*;
#(
  parameter int width          = 8,
  parameter int address_width  = 4,
  parameter int rx_address     = RX_ADDR,
  parameter int tx_address     = TX_ADDR,
  parameter int status_address = STATUS_ADDR,
  parameter int rx_ready_bit   = RX_READY_BIT,
  parameter int tx_ready_bit   = TX_READY_BIT
) (
  input  logic                     clock,
  input  logic                     reset,
  output logic                     read_enable,
  output logic                     write_enable,
  output logic [address_width-1:0] active_address,
  output logic [width-1:0]         data_in,
  input  logic [width-1:0]         data_out,
  input  logic [width-1:0]         tx_data,
  input  logic                     tx_valid,
  output logic                     tx_ready,
  output logic [width-1:0]         rx_data,
  output logic                     rx_valid,
  input  logic                     rx_ready
`ifdef BUFF_UART_DRIVER_STATS_EN
  ,
  output logic [15:0]              rx_count,
  output logic [15:0]              tx_count
`endif
);

  driver_state_t           state_q, state_d;
  last_served_t            last_served_q;
  logic                    tx_full_q, tx_full_d;
  logic [width-1:0]        tx_byte_q;
  logic                    tx_ready_q;
  logic                    rx_valid_q;
  logic [width-1:0]        rx_data_q;
  logic                    read_enable_q, write_enable_q;
  logic [address_width-1:0] active_address_q;
  logic [width-1:0]        data_in_q;
  logic                    rx_ok, tx_ok, tx_accept;

  assign tx_accept = tx_valid && tx_ready_q;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    rx_ok     = data_out[rx_ready_bit] && !rx_valid_q;
    tx_ok     = data_out[tx_ready_bit] && tx_full_q;
    tx_full_d = tx_full_q;
    state_d   = state_q;

    if (tx_accept)
      tx_full_d = 1'b1;
    else if (state_q == TX_WRITE)
      tx_full_d = 1'b0;

    case (state_q)
      IDLE:      state_d = STAT_REQ;
      STAT_REQ:  state_d = STAT_WAIT;
      STAT_WAIT: begin
        if (rx_ok && tx_ok)
          state_d = (last_served_q == SERVED_TX) ? RX_REQ : TX_WRITE;
        else if (rx_ok)
          state_d = RX_REQ;
        else if (tx_ok)
          state_d = TX_WRITE;
        else
          state_d = STAT_REQ;
      end
      RX_REQ:    state_d = RX_WAIT;
      RX_WAIT:   state_d = STAT_REQ;
      TX_WRITE:  state_d = STAT_REQ;
      default:   state_d = IDLE;
    endcase
  end

  // Bus outputs are decoded from the next state so they come straight off flops.
  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q          <= IDLE;
      last_served_q    <= SERVED_TX;
      tx_full_q        <= 1'b0;
      tx_byte_q        <= '0;
      tx_ready_q       <= 1'b0;
      rx_valid_q       <= 1'b0;
      rx_data_q        <= '0;
      read_enable_q    <= 1'b0;
      write_enable_q   <= 1'b0;
      active_address_q <= '0;
      data_in_q        <= '0;
    end else begin
      state_q    <= state_d;
      tx_full_q  <= tx_full_d;
      tx_ready_q <= !tx_full_d;

      if (tx_accept)
        tx_byte_q <= tx_data;

      if (state_q == TX_WRITE)
        last_served_q <= SERVED_TX;

      if (state_q == RX_WAIT) begin
        rx_data_q     <= data_out;
        rx_valid_q    <= 1'b1;
        last_served_q <= SERVED_RX;
      end else if (rx_valid_q && rx_ready) begin
        rx_valid_q <= 1'b0;
      end

      read_enable_q  <= (state_d == STAT_REQ) || (state_d == RX_REQ);
      write_enable_q <= (state_d == TX_WRITE);
      data_in_q      <= (state_d == TX_WRITE) ? tx_byte_q : '0;

      case (state_d)
        STAT_REQ: active_address_q <= address_width'(status_address);
        RX_REQ:   active_address_q <= address_width'(rx_address);
        TX_WRITE: active_address_q <= address_width'(tx_address);
        default:  active_address_q <= '0;
      endcase
    end
  end

`ifdef BUFF_UART_DRIVER_STATS_EN
  logic [15:0] rx_count_q, tx_count_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      rx_count_q <= '0;
      tx_count_q <= '0;
    end else begin
      if (state_q == RX_WAIT)
        rx_count_q <= rx_count_q + 16'd1;
      if (state_q == TX_WRITE)
        tx_count_q <= tx_count_q + 16'd1;
    end
  end

  assign rx_count = rx_count_q;
  assign tx_count = tx_count_q;
`endif

  assign read_enable    = read_enable_q;
  assign write_enable   = write_enable_q;
  assign active_address = active_address_q;
  assign data_in        = data_in_q;
  assign tx_ready       = tx_ready_q;
  assign rx_valid       = rx_valid_q;
  assign rx_data        = rx_data_q;

endmodule
